// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and parity helper,
// common to the receiver and transmitter.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;
    localparam int SAMPLE_END = 15;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    // Parity bit a transmitter would send for this byte.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus falling-edge (start) detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic start_edge
);

    logic rx_meta;
    logic rx_prev;

    // All stages reset high so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_8bit.sv
// 16x oversampled UART receiver: start, 8 data bits LSB first, parity, stop.
// Emits a one-cycle valid per completed frame with parity/framing flags.
module uart_rx_8bit
    import uart_pkg::*;
#(
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [3:0] CNT_END  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] CNT_MID  = 4'(SAMPLE_MID);
    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);
    localparam logic       ODD_SEL  = (PARITY_ODD != 0);

    logic        rx_s;
    logic        start_edge;
    uart_state_t state;
    uart_state_t state_next;
    logic [3:0]  cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic        par_bit;
    logic        cnt_clr;
    logic        idx_clr;
    logic        sample_data;
    logic        sample_par;
    logic        sample_stop;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        idx_clr     = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                    cnt_clr    = 1'b1;
                    idx_clr    = 1'b1;
                end
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (cnt == CNT_MID) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_END) begin
                    sample_data = 1'b1;
                    if (idx == IDX_LAST) state_next = PARITY;
                end
            end
            PARITY: begin
                if (cnt == CNT_END) begin
                    sample_par = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_END) begin
                    sample_stop = 1'b1;
                    state_next  = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // cnt free-runs and wraps 15->0 so sample points stay one bit period apart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            idx        <= 3'd0;
            shift      <= 8'd0;
            par_bit    <= 1'b0;
            data_out   <= 8'd0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state <= state_next;
            valid <= sample_stop;
            cnt   <= cnt_clr ? 4'd0 : cnt + 4'd1;
            if (idx_clr)
                idx <= 3'd0;
            else if (sample_data)
                idx <= idx + 3'd1;
            if (sample_data)
                shift <= {rx_s, shift[7:1]};
            if (sample_par)
                par_bit <= rx_s;
            if (sample_stop) begin
                data_out   <= shift;
                parity_err <= (parity_of(shift, ODD_SEL) != par_bit);
                frame_err  <= ~rx_s;
            end
        end
    end

endmodule
